gcd_rr_arbiter: RTL

Shares one gcdGCDUnit_rtl instance among NUM_REQ requesters, each with its own val/rdy operand port and val/rdy result port. Round-robin arbiter with one operation outstanding. The block latches the winner's operands, issues them to the GCD unit, then routes the result back to the owning requester only. Sits between client blocks (or vcTestSource/vcTestSink instances in benches) and the GCD unit.

---
 rtl/gcd_rr_arbiter_pkg.sv | 24 ++
 rtl/gcd_rr_arbiter_if.sv | 43 ++++
 rtl/gcd_rr_pick.sv | 36 +++
 rtl/gcd_rr_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gcd_rr_arbiter_pkg.sv
// Shared definitions for the GCD round-robin arbiter and other GCD-side blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gcd_rr_arbiter_pkg;

    // Controller state. Code 3 is unused and is treated as a fault that
    // recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Ceiling log2 for sizing index registers; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_rr_arbiter_if.sv
// Bundle of requester-side and GCD-unit-side handshakes around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: val/rdy on every channel; a beat moves when both are high.
//
// master: the arbiter's view. slave: the clients plus the GCD unit.
// Requester operands are packed per slot: slot i is bits [i*W +: W].
interface gcd_rr_arbiter_if #(
    parameter int W       = 16,
    parameter int NUM_REQ = 4
);
    // Requester operand channels
    logic [NUM_REQ*W-1:0] req_bits_A;
    logic [NUM_REQ*W-1:0] req_bits_B;
    logic [NUM_REQ-1:0]   req_val;
    logic [NUM_REQ-1:0]   req_rdy;
    // Requester result channels (data shared, valid steered)
    logic [W-1:0]         resp_bits_data;
    logic [NUM_REQ-1:0]   resp_val;
    logic [NUM_REQ-1:0]   resp_rdy;
    // GCD unit operand channel
    logic [W-1:0]         operands_bits_A;
    logic [W-1:0]         operands_bits_B;
    logic                 operands_val;
    logic                 operands_rdy;
    // GCD unit result channel
    logic [W-1:0]         result_bits_data;
    logic                 result_val;
    logic                 result_rdy;

    modport master (
        input  req_bits_A, req_bits_B, req_val, resp_rdy,
        input  operands_rdy, result_bits_data, result_val,
        output req_rdy, resp_bits_data, resp_val,
        output operands_bits_A, operands_bits_B, operands_val, result_rdy
    );

    modport slave (
        output req_bits_A, req_bits_B, req_val, resp_rdy,
        output operands_rdy, result_bits_data, result_val,
        input  req_rdy, resp_bits_data, resp_val,
        input  operands_bits_A, operands_bits_B, operands_val, result_rdy
    );
endinterface

// File: rtl/gcd_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports: req_i (request vector), ptr_i (highest-priority slot),
//        gnt_o (one-hot grant), idx_o (grant index), any_o (some request set).
module gcd_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap with an explicit modulo so N need not be a power of two.
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_arbiter.sv
// Shares one GCD unit among NUM_REQ requesters, one operation in flight.
// Latency: 1 cycle grant (IDLE) + >=1 cycle issue (SEND) + GCD unit latency.
// Backpressure: no grant while busy; result held in WAIT until owner is ready.
//
// Ports: clk, reset (async, active-low), bus (gcd_rr_arbiter_if.master):
//   requester operands in / req_rdy out, steered result out / resp_rdy in,
//   operands out to the GCD unit, result in from the GCD unit.
module gcd_rr_arbiter
    import gcd_rr_arbiter_pkg::*;
#(
    parameter int W       = 16,
    parameter int NUM_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    gcd_rr_arbiter_if.master bus
);

    localparam int IDX_W = clog2(NUM_REQ);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [W-1:0]       a_sel, b_sel;
    logic [NUM_REQ-1:0] req_rdy;
    logic [NUM_REQ-1:0] resp_val;
    logic [W-1:0]       resp_data;
    logic               operands_val;
    logic               result_rdy;

    gcd_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (bus.req_val),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Operand mux for the current winner.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                a_sel = bus.req_bits_A[i*W +: W];
                b_sel = bus.req_bits_B[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        req_rdy      = '0;
        resp_val     = '0;
        resp_data    = '0;
        operands_val = 1'b0;
        result_rdy   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready only goes to a requester whose valid is high, so a
                // grant in IDLE is always a fire.
                req_rdy = pick_gnt;
                if (pick_any) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    owner_d = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                operands_val = 1'b1;
                if (bus.operands_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Result path is pass-through; the GCD unit holds its result
                // while the owner stalls.
                result_rdy        = bus.resp_rdy[owner_q];
                resp_val[owner_q] = bus.result_val;
                resp_data         = bus.result_bits_data;
                if (bus.result_val && bus.resp_rdy[owner_q]) begin
                    ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : owner_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is held so that a pending
        // request cannot see ready during reset.
        if (!reset) begin
            req_rdy      = '0;
            resp_val     = '0;
            resp_data    = '0;
            operands_val = 1'b0;
            result_rdy   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.req_rdy         = req_rdy;
    assign bus.resp_val        = resp_val;
    assign bus.resp_bits_data  = resp_data;
    assign bus.operands_val    = operands_val;
    assign bus.operands_bits_A = a_q;
    assign bus.operands_bits_B = b_q;
    assign bus.result_rdy      = result_rdy;

endmodule
